// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, FSM states and command layout for the ALU sequencer
package alu_pkg;

  localparam int ALU_DW  = 4;
  localparam int ALU_OPW = 2;
  localparam int ALU_RW  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [ALU_OPW-1:0] op;
    logic [ALU_DW-1:0]  a;
    logic [ALU_DW-1:0]  b;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - power-of-two command FIFO with registered occupancy
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  cmd_t                   wdata,
  output cmd_t                   rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Guards keep pointers coherent even if a caller pushes when full or pops when empty.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == DEPTH[AW:0]);
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_seq.sv
// rtl/alu_cmd_seq.sv - feeds queued commands to an external combinational ALU and returns results
module alu_cmd_seq
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ALU_DW-1:0]      cmd_a,
  input  logic [ALU_DW-1:0]      cmd_b,
  input  logic [ALU_OPW-1:0]     cmd_op,
  output logic [ALU_DW-1:0]      alu_a,
  output logic [ALU_DW-1:0]      alu_b,
  output logic [ALU_OPW-1:0]     alu_s,
  input  logic [ALU_RW-1:0]      alu_f,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ALU_RW-1:0]      res_data,
  output logic [ALU_OPW-1:0]     res_op,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);

  state_t state;
  state_t state_nxt;
  cmd_t   head;
  logic   full;
  logic   empty;
  logic   push;
  logic   pop;
  logic   capture;
  logic   res_accept;

  // Ready comes only from registered occupancy, so a pop never re-opens it in the same cycle.
  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE) || (count != '0);

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({cmd_op, cmd_a, cmd_b}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    capture    = 1'b0;
    res_accept = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        capture   = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        if (res_ready) begin
          res_accept = 1'b1;
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = EXEC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ALU operands change only on a pop; the ALU output is sampled one cycle after loading.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s     <= '0;
      res_data  <= '0;
      res_op    <= '0;
      res_valid <= 1'b0;
    end else begin
      if (pop) begin
        alu_a <= head.a;
        alu_b <= head.b;
        alu_s <= head.op;
      end
      if (capture) begin
        res_data  <= alu_f;
        res_op    <= alu_s;
        res_valid <= 1'b1;
      end else if (res_accept) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// tb/tb_alu_cmd_seq.sv - self-checking bench for alu_cmd_seq with a stage-level reference model
module tb_alu_cmd_seq;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_s;
  logic [7:0] alu_f;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [1:0] res_op;
  logic [$clog2(DEPTH):0] count;
  logic       busy;

  bit mode;
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  alu_cmd_seq #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s     (alu_s),
    .alu_f     (alu_f),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_op    (res_op),
    .count     (count),
    .busy      (busy)
  );

  // Mode 0: arithmetic ALU (add, sub, mul, xor); mode 1: F = {A, B}.
  function automatic logic [7:0] alu_fn(input bit m, input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] s);
    logic [7:0] ea;
    logic [7:0] eb;
    ea = {4'b0, a};
    eb = {4'b0, b};
    if (m) return {a, b};
    case (s)
      2'd0:    return ea + eb;
      2'd1:    return ea - eb;
      2'd2:    return ea * eb;
      default: return ea ^ eb;
    endcase
  endfunction

  assign alu_f = alu_fn(mode, alu_a, alu_b, alu_s);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a queue of waiting commands plus one in-flight slot that is
  // either loaded on the ALU (result due next edge) or presented to the consumer.
  logic [9:0] m_q[$];
  bit         m_init = 0;
  bit         m_loaded;
  bit         m_pres;
  logic [3:0] m_a;
  logic [3:0] m_b;
  logic [1:0] m_s;
  logic [7:0] m_rd;
  logic [1:0] m_rop;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_loaded = 0;
      m_pres   = 0;
      m_a = 0; m_b = 0; m_s = 0; m_rd = 0; m_rop = 0;
      m_init = 1;
    end else if (m_init) begin
      bit do_push;
      bit do_pop;
      logic [9:0] c;
      do_push = cmd_valid && (m_q.size() < DEPTH);
      do_pop  = (m_q.size() != 0) && ((!m_loaded && !m_pres) || (m_pres && res_ready));
      if (m_pres && res_ready) m_pres = 0;
      if (m_loaded) begin
        m_rd     = alu_fn(mode, m_a, m_b, m_s);
        m_rop    = m_s;
        m_pres   = 1;
        m_loaded = 0;
      end
      if (do_pop) begin
        c = m_q.pop_front();
        {m_s, m_a, m_b} = c;
        m_loaded = 1;
      end
      if (do_push) m_q.push_back({cmd_op, cmd_a, cmd_b});
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("cmd_ready", cmd_ready, !rst && (m_q.size() < DEPTH));
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_s", alu_s, m_s);
      chk("res_valid", res_valid, m_pres);
      chk("res_data", res_data, m_rd);
      chk("res_op", res_op, m_rop);
      chk("count", count, m_q.size());
      chk("busy", busy, m_loaded || m_pres || (m_q.size() != 0));
    end
  end

  // End-to-end scoreboard: every accepted result matches the pushed commands in order.
  logic [9:0] sb[$];
  logic [7:0] acc_d[$];
  int         acc_c[$];

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (res_valid && res_ready) begin
        acc_d.push_back(res_data);
        acc_c.push_back(cyc);
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_extra: unexpected result %0h", res_data);
        end else begin
          logic [9:0] e;
          e = sb.pop_front();
          chk("sb_data", res_data, e[7:0]);
          chk("sb_op", res_op, e[9:8]);
        end
      end
      if (cmd_valid && cmd_ready) sb.push_back({cmd_op, alu_fn(mode, cmd_a, cmd_b, cmd_op)});
    end
  end

  task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    int t = 0;
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL push_timeout: cmd_ready stuck at 0");
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int t = 0;
    while (busy && t < lim) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_idle: busy still %0d after %0d cycles", busy, lim);
    end
  endtask

  initial begin
    int base;
    int acc_n;
    int i;
    int t;
    logic [7:0] exp_stream [4];
    exp_stream = '{8'h12, 8'h34, 8'h56, 8'h78};

    rst = 1'b1;
    cmd_valid = 1'b1;
    cmd_a = 4'h3; cmd_b = 4'h5; cmd_op = 2'd2;
    res_ready = 1'b0;
    mode = 0;

    // Reset held 3 cycles with cmd_valid high.
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_count", count, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk("rel_cmd_ready", cmd_ready, 1);

    // Single command: 4 - 4 on the arithmetic ALU.
    push_cmd(4'b0100, 4'b0100, 2'b01);
    @(posedge clk);
    @(negedge clk);
    chk("single_alu_a", alu_a, 4'b0100);
    chk("single_alu_b", alu_b, 4'b0100);
    chk("single_alu_s", alu_s, 2'b01);
    chk("single_early_valid", res_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("single_valid", res_valid, 1);
    chk("single_data", res_data, 8'h00);
    chk("single_op", res_op, 2'b01);
    res_ready = 1'b1;
    wait_idle(20);

    // Stream order and throughput with F = {A, B}.
    mode = 1;
    base = acc_d.size();
    push_cmd(4'd1, 4'd2, 2'd0);
    push_cmd(4'd3, 4'd4, 2'd1);
    push_cmd(4'd5, 4'd6, 2'd2);
    push_cmd(4'd7, 4'd8, 2'd3);
    wait_idle(40);
    chk("stream_n", acc_d.size() - base, 4);
    if (acc_d.size() - base == 4) begin
      for (int k = 0; k < 4; k++) chk("stream_data", acc_d[base+k], exp_stream[k]);
      for (int k = 1; k < 4; k++) chk("stream_gap", acc_c[base+k] - acc_c[base+k-1], 2);
    end

    // Full FIFO under backpressure.
    res_ready = 1'b0;
    base = acc_d.size();
    acc_n = 0;
    i = 0;
    t = 0;
    cmd_valid = 1'b1;
    cmd_a = 4'd1; cmd_b = 4'd8; cmd_op = 2'd0;
    while (t < 30) begin
      if (!cmd_ready) break;
      acc_n++;
      @(posedge clk);
      #1;
      i++;
      cmd_a = 4'(i + 1);
      cmd_b = 4'(i + 8);
      @(negedge clk);
      t++;
    end
    cmd_valid = 1'b0;
    chk("full_accepted", acc_n, 5);
    chk("full_count", count, 4);
    chk("full_valid", res_valid, 1);
    chk("full_data", res_data, 8'h18);
    repeat (3) @(negedge clk);
    chk("full_stable", res_data, 8'h18);
    res_ready = 1'b1;
    wait_idle(60);
    chk("full_drain_n", acc_d.size() - base, 5);
    if (acc_d.size() - base == 5)
      for (int k = 0; k < 5; k++) chk("full_drain_data", acc_d[base+k], {4'(k + 1), 4'(k + 8)});
    chk("full_ready_back", cmd_ready, 1);

    // Push coinciding with a DONE-accept pop while two commands wait.
    res_ready = 1'b0;
    base = acc_d.size();
    push_cmd(4'd1, 4'd1, 2'd0);
    push_cmd(4'd2, 4'd2, 2'd0);
    push_cmd(4'd3, 4'd3, 2'd0);
    chk("sim_pre_count", count, 2);
    chk("sim_pre_valid", res_valid, 1);
    cmd_valid = 1'b1;
    cmd_a = 4'd4; cmd_b = 4'd4; cmd_op = 2'd1;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    chk("sim_count", count, 2);
    res_ready = 1'b1;
    wait_idle(40);
    chk("sim_n", acc_d.size() - base, 4);
    if (acc_d.size() - base == 4) begin
      chk("sim_first", acc_d[base], 8'h11);
      chk("sim_last", acc_d[base+3], 8'h44);
    end

    // Reset while DONE with three queued.
    res_ready = 1'b0;
    push_cmd(4'd5, 4'd5, 2'd0);
    push_cmd(4'd6, 4'd6, 2'd0);
    push_cmd(4'd7, 4'd7, 2'd0);
    push_cmd(4'd8, 4'd8, 2'd0);
    chk("mid_pre_count", count, 3);
    chk("mid_pre_valid", res_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_valid", res_valid, 0);
    chk("mid_count", count, 0);
    base = acc_d.size();
    push_cmd(4'd9, 4'd7, 2'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid_new_valid", res_valid, 1);
    chk("mid_new_data", res_data, 8'h97);
    res_ready = 1'b1;
    wait_idle(20);
    chk("mid_no_stale", acc_d.size() - base, 1);

    // Randomised traffic with occasional resets on the arithmetic ALU.
    mode = 0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      rst       = ($urandom_range(0, 299) == 0);
      cmd_valid = ($urandom_range(0, 9) < 6);
      cmd_a     = 4'($urandom);
      cmd_b     = 4'($urandom);
      cmd_op    = 2'($urandom);
      res_ready = 1'($urandom);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    wait_idle(60);
    chk("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_seq.md
# alu_cmd_seq

Command sequencer that sits directly upstream of the 4-bit ALU (`ALU_4bit`) and also captures its 8-bit result. It buffers operand/opcode commands in a small FIFO, presents one command at a time on registered ALU operand ports, and samples the combinational ALU output one cycle later. It returns each result on a valid/ready interface. It turns the free-running combinational ALU into a flow-controlled, one-result-per-command stage.

## Interface
- `DEPTH`, 4: command FIFO depth; power of 2, ≥2.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: FIFO can accept; equals `!full && !rst`.
- `cmd_a` in 4: operand A.
- `cmd_b` in 4: operand B.
- `cmd_op` in 2: ALU select code; passed through unmodified.
- `alu_a` out 4: registered operand A to ALU `A`.
- `alu_b` out 4: registered operand B to ALU `B`.
- `alu_s` out 2: registered select to ALU `S`.
- `alu_f` in 8: ALU result `F` (combinational from `alu_a/b/s`).
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts.
- `res_data` out 8: captured ALU result.
- `res_op` out 2: opcode that produced `res_data`.
- `count` out $clog2(DEPTH)+1: FIFO occupancy.
- `busy` out 1: `state != IDLE || count != 0`.

## Operation
- A push occurs at an edge where `cmd_valid && cmd_ready`. It writes `{cmd_op, cmd_a, cmd_b}` at the write pointer.
- A pop occurs only under the FSM rules below. Pointers wrap modulo `DEPTH`.
- FSM states are IDLE, EXEC, and DONE.
- IDLE:
  - If `count != 0` at the edge: pop the head, load `alu_a/alu_b/alu_s`, and go to EXEC.
  - Otherwise stay in IDLE.
- EXEC:
  - Capture `res_data <= alu_f` and `res_op <= alu_s`.
  - Set `res_valid <= 1` and go to DONE.
- DONE:
  - Hold `res_data/res_op` stable while `res_valid && !res_ready`.
  - On `res_ready`, clear `res_valid`.
  - If `count != 0` at that same edge, pop the next command, load the operands, and go to EXEC (back-to-back).
  - Otherwise go to IDLE.
- `alu_a/b/s` hold their last loaded values until the next pop. They never change outside a pop edge.
- A push and a pop at the same edge are both performed, and `count` is unchanged.
- A push into an empty FIFO is not popped on that same edge. The FSM sees `count != 0` from the next edge on.
- Full FIFO: `cmd_ready` = 0. A pop does not re-open `cmd_ready` within the same cycle (no ready-through).
- Commands are processed in strict FIFO order. No command is dropped or duplicated.

## Timing
- Reset values:
  - State is IDLE.
  - Pointers and `count` are 0.
  - `alu_a`, `alu_b`, `alu_s`, `res_data`, and `res_op` are 0.
  - `res_valid` and `busy` are 0.
  - `cmd_ready` is 0 while `rst` is high, and 1 in the first cycle after it falls.
- Reset mid-operation discards all FIFO contents and any pending result. No result is emitted for discarded commands.
- Latency:
  - A command pushed at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1.
  - `alu_a/b/s` are valid after N+1.
  - `alu_f` is sampled at edge N+2.
  - `res_valid` is high after edge N+2.
- Throughput with `res_ready` held at 1: one result every 2 cycles.
- `res_valid` is asserted for at least one cycle. Deassertion happens only at an accepting edge.

## Structure
- Package `alu_pkg`:
  - Constants: `ALU_DW` = 4, `ALU_OPW` = 2, `ALU_RW` = 8.
  - FSM state enum: IDLE, EXEC, DONE.
  - Packed command type: op, a, b.
- Sub-module `alu_cmd_fifo`:
  - Parameterised by `DEPTH`.
  - Ports: push/pop/data in/out, `full`, `empty`, `count`.
  - Synchronous active-high reset.
- `alu_cmd_seq` contains the FSM and the operand/result registers.
- The ALU is instantiated by the integrator, not inside this block.

## Test plan
- **Reset check.** Stimulus: hold `rst` 3 cycles with `cmd_valid` = 1, then release. Required response: all outputs 0 during reset; no push occurs; `cmd_ready` = 1 on the first cycle after release.
- **Single command through the real ALU.** Stimulus: connect `ALU_4bit`; push A=4'b0100, B=4'b0100, op=2'b01 at edge N. Required response: `alu_a/b/s` = 0100/0100/01 after N+1; `res_valid` high after N+2 with `res_data` = 8'b0000_0000 (A−B) and `res_op` = 01.
- **Stream order and throughput.** Stimulus: bench ALU model F = {alu_a, alu_b}; push (1,2), (3,4), (5,6), (7,8) back-to-back with `res_ready` = 1. Required response: results 8'h12, 8'h34, 8'h56, 8'h78 in that order, spaced 2 cycles apart.
- **Full FIFO and backpressure.** Stimulus: `res_ready` = 0; push until `cmd_ready` falls. Required response: `count` = 4 with 1 command in DONE (5 accepted); `res_data` stable; releasing `res_ready` drains all 5 in order, and `cmd_ready` returns.
- **Simultaneous push and pop.** Stimulus: push at the same edge as a DONE-accept pop with `count` = 2. Required response: `count` stays 2; the new command is delivered last.
- **Reset mid-operation.** Stimulus: assert `rst` for 1 cycle while in DONE with 3 queued. Required response: `res_valid` = 0 and `count` = 0; no stale result appears afterwards; the next pushed command yields its result 2 cycles after being pushed.
